msg_tx_controller: RTL and testbench
====================================

Name: msg_tx_controller

Overview:
Sequences outbound messages for the GPIO link. Collects ASCII characters from the PS/2 decode path into a 16-byte message buffer and handles delete. On a send request, or automatically when the buffer fills, it runs the data_ready/write_done handshake with gpio_protocol. It sits between the keyboard ASCII decoder and gpio_protocol, replacing the ad-hoc counter and edge-triggered data_ready logic at the top level.

Parameters:
MSG_BYTES, 16, message length in bytes; message bus width is 8*MSG_BYTES.
AUTO_SEND, 1, 1 = start a send automatically when the last byte slot is written.
TIMEOUT_CYCLES, 1024, clock cycles to wait in SEND for write_done before aborting.
SYNC_STAGES, 2, flip-flop stages on the write_done input (link side is slower and asynchronous).

Ports:
clock  input  1  single system clock
reset  input  1  asynchronous, active-high reset
char_valid  input  1  one-cycle strobe; char_data is valid
char_data  input  8  ASCII character; 8'd127 = delete
send_req  input  1  one-cycle strobe requesting transmission of the current buffer
write_done  input  1  level from gpio_protocol; high = transfer complete
message_out  output  128  packed buffer; byte 0 in [127:120], byte 15 in [7:0]
data_ready  output  1  registered request to gpio_protocol
char_count  output  5  bytes currently held, 0..16
busy  output  1  high in every state except COLLECT
dropped  output  1  one-cycle pulse when a character or delete is discarded
timeout  output  1  one-cycle pulse when a send aborts on timeout

Behaviour:
- Reset (async, immediate): state=COLLECT; all buffer bytes=8'h00; char_count=0; data_ready=0; busy=0; dropped=0; timeout=0; sync chain cleared.
- write_done is used only after the SYNC_STAGES synchronizer (wd_s).
- States: COLLECT, SEND, RELEASE.
- COLLECT, char_valid with char != 127:
  - If count < 16: byte[count] <= char and count += 1 on the next edge.
  - If count = 16: the character is discarded and dropped pulses.
- COLLECT, char_valid with char = 127:
  - If count > 0: count -= 1 and byte[count-1] <= 8'h00.
  - If count = 0: the delete is ignored; no dropped pulse.
- COLLECT to SEND transitions:
  - send_req with count > 0 moves to SEND.
  - send_req with count = 0 is ignored.
  - If AUTO_SEND=1 and a write brings count to 16, the next state is SEND.
- Simultaneous char_valid and send_req in COLLECT: the character (or delete) is applied first; the state moves to SEND in the same edge. The sent message includes that character. If a delete empties the buffer, the send is ignored.
- SEND:
  - data_ready=1 from the first SEND cycle (registered, 1 cycle after the triggering edge).
  - message_out is frozen.
  - A timeout counter increments each cycle.
  - wd_s=1 moves to RELEASE.
  - If the counter reaches TIMEOUT_CYCLES-1 without wd_s: data_ready returns to 0, timeout pulses, state returns to COLLECT, and the buffer and count are retained.
- RELEASE:
  - data_ready=0.
  - Waits for wd_s=0, then clears all bytes to 8'h00 and count to 0, and returns to COLLECT.
  - No timeout applies in RELEASE.
- char_valid in SEND or RELEASE: discarded and dropped pulses (delete included). send_req in SEND or RELEASE is ignored.
- wd_s already high on entry to SEND: RELEASE is entered the next cycle (stale-done case). Handshake correctness relies on gpio_protocol dropping done when data_ready falls.
- Reset asserted mid-SEND: data_ready drops asynchronously and the buffer is lost.
- Arithmetic: count is 5 bits and saturates at 16 and at 0; there is no wrap-around.

Decomposition:
- Shared package msg_ctrl_pkg:
  - state enum {COLLECT, SEND, RELEASE}
  - ASCII_DEL = 8'd127
  - ASCII_SPACE = 8'd32
  - MSG_BYTES_DEFAULT = 16
- One sub-module, sync_nff: parameterised SYNC_STAGES flip-flop synchronizer with async active-high reset, used for write_done.
- The buffer, counter and FSM stay in msg_tx_controller.

Test Plan:
- Type "hi" (0x68, 0x69), then send_req → message_out[127:112]=16'h6869, rest 0; data_ready rises 1 cycle after send_req. Raise write_done → after SYNC_STAGES+1 cycles data_ready=0. Drop write_done → count=0 and message_out=0.
- AUTO_SEND=1, write 16 × 0x61 → data_ready=1 after the 16th strobe; a 17th char during SEND → dropped pulse, message_out unchanged (all 0x61).
- Enter "ab", then 127, 127, 127 → count goes 2,1,0,0; no dropped pulse; message_out=0. Then send_req → no data_ready.
- TIMEOUT_CYCLES=8, send "x" with write_done held 0 → timeout pulse 8 cycles after SEND entry; data_ready=0; count stays 1; byte0=0x78.
- Same-cycle char_valid=0x7A and send_req with count=0 → SEND entered; message_out[127:120]=0x7A.
- Assert reset during SEND → data_ready, count and message_out are 0 immediately, before the next clock edge; state is COLLECT.

Source files
------------

// File: rtl/msg_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// msg_ctrl_pkg
// Shared types and constants for the outbound message controller.
//   state_t            : controller states (COLLECT, SEND, RELEASE)
//   ASCII_DEL          : character code that removes the last buffered byte
//   ASCII_SPACE        : printable space, lowest ordinary character of interest
//   MSG_BYTES_DEFAULT  : default message length in bytes
// -----------------------------------------------------------------------------
package msg_ctrl_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_DEL         = 8'd127;
    localparam logic [7:0] ASCII_SPACE       = 8'd32;
    localparam int         MSG_BYTES_DEFAULT = 16;

endpackage

// File: rtl/sync_nff.sv
// -----------------------------------------------------------------------------
// sync_nff
// N-stage flip-flop synchronizer for a single asynchronous level.
// Ports:
//   clock : destination clock
//   reset : asynchronous, active-high; clears every stage
//   d     : asynchronous input level
//   q     : synchronized level, SYNC_STAGES clocks of latency
// -----------------------------------------------------------------------------
module sync_nff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // NOTE: clocked state is always updated with non-blocking assignments so
    // every stage samples the value its neighbour held before the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/msg_tx_controller.sv
// -----------------------------------------------------------------------------
// msg_tx_controller
// Collects ASCII characters into a MSG_BYTES message buffer (with delete), and
// on a send request -- or automatically when the buffer fills -- runs the
// data_ready / write_done handshake towards gpio_protocol.
// Ports:
//   clock       : system clock
//   reset       : asynchronous, active-high
//   char_valid  : one-cycle strobe, char_data valid
//   char_data   : ASCII character, 8'd127 = delete
//   send_req    : one-cycle strobe, transmit current buffer
//   write_done  : asynchronous level from gpio_protocol, high = transfer done
//   message_out : packed buffer, byte 0 in the most significant byte
//   data_ready  : registered transfer request
//   char_count  : bytes held, 0..MSG_BYTES
//   busy        : high whenever not collecting
//   dropped     : one-cycle pulse when a character or delete is discarded
//   timeout     : one-cycle pulse when a send is abandoned
// -----------------------------------------------------------------------------
module msg_tx_controller
    import msg_ctrl_pkg::*;
#(
    parameter int MSG_BYTES      = MSG_BYTES_DEFAULT,
    parameter bit AUTO_SEND      = 1'b1,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             char_valid,
    input  logic [7:0]                       char_data,
    input  logic                             send_req,
    input  logic                             write_done,
    output logic [8*MSG_BYTES-1:0]           message_out,
    output logic                             data_ready,
    output logic [$clog2(MSG_BYTES+1)-1:0]   char_count,
    output logic                             busy,
    output logic                             dropped,
    output logic                             timeout
);

    localparam int CNT_W = $clog2(MSG_BYTES + 1);
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t           state, state_nxt;
    logic [7:0]       buf_q [MSG_BYTES];
    logic [7:0]       buf_d [MSG_BYTES];
    logic [CNT_W-1:0] count_q, count_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             full_hit;
    logic             dropped_d, timeout_d;
    logic             wd_s;

    sync_nff #(.SYNC_STAGES(SYNC_STAGES)) u_wd_sync (
        .clock (clock),
        .reset (reset),
        .d     (write_done),
        .q     (wd_s)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        buf_d     = buf_q;
        count_d   = count_q;
        tmr_d     = tmr_q;
        full_hit  = 1'b0;
        dropped_d = 1'b0;
        timeout_d = 1'b0;

        case (state)
            COLLECT: begin
                tmr_d = '0;
                if (char_valid) begin
                    if (char_data == ASCII_DEL) begin
                        if (count_q != '0) begin
                            count_d = count_q - 1'b1;
                            for (int i = 0; i < MSG_BYTES; i++) begin
                                if (CNT_W'(i) == count_d) buf_d[i] = 8'h00;
                            end
                        end
                    end else if (count_q < CNT_W'(MSG_BYTES)) begin
                        count_d = count_q + 1'b1;
                        for (int i = 0; i < MSG_BYTES; i++) begin
                            if (CNT_W'(i) == count_q) buf_d[i] = char_data;
                        end
                        full_hit = AUTO_SEND && (count_d == CNT_W'(MSG_BYTES));
                    end else begin
                        dropped_d = 1'b1;
                    end
                end
                // The character is applied first; a send only proceeds if
                // the resulting buffer is non-empty.
                if ((send_req && count_d != '0) || full_hit) begin
                    state_nxt = SEND;
                end
            end

            SEND: begin
                dropped_d = char_valid;
                if (wd_s) begin
                    state_nxt = RELEASE;
                end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_nxt = COLLECT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            RELEASE: begin
                dropped_d = char_valid;
                // Wait for the link to drop done before reusing the buffer.
                if (!wd_s) begin
                    for (int i = 0; i < MSG_BYTES; i++) buf_d[i] = 8'h00;
                    count_d   = '0;
                    state_nxt = COLLECT;
                end
            end

            default: state_nxt = COLLECT;
        endcase
    end

    // NOTE: the buffer is a handful of flops, not a RAM, so it is reset along
    // with the rest of the state and message_out reads as zero after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= COLLECT;
            count_q    <= '0;
            tmr_q      <= '0;
            data_ready <= 1'b0;
            dropped    <= 1'b0;
            timeout    <= 1'b0;
            for (int i = 0; i < MSG_BYTES; i++) buf_q[i] <= 8'h00;
        end else begin
            state      <= state_nxt;
            count_q    <= count_d;
            tmr_q      <= tmr_d;
            data_ready <= (state_nxt == SEND);
            dropped    <= dropped_d;
            timeout    <= timeout_d;
            for (int i = 0; i < MSG_BYTES; i++) buf_q[i] <= buf_d[i];
        end
    end

    for (genvar g = 0; g < MSG_BYTES; g++) begin : g_pack
        assign message_out[8*(MSG_BYTES-g)-1 -: 8] = buf_q[g];
    end

    assign char_count = count_q;
    assign busy       = (state != COLLECT);

endmodule

// File: tb/tb_msg_tx_controller.sv
// -----------------------------------------------------------------------------
// tb_msg_tx_controller
// Self-checking bench: directed scenarios with literal expectations, then a
// randomized run. A queue-based model of the message buffer and handshake is
// advanced on every clock and compared against the DUT on every falling edge.
// -----------------------------------------------------------------------------
module tb_msg_tx_controller;

    localparam int NB   = 16;
    localparam int TMO  = 8;
    localparam int SYNC = 2;

    localparam int P_COLLECT = 0;
    localparam int P_SEND    = 1;
    localparam int P_REL     = 2;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         char_valid = 1'b0;
    logic [7:0]   char_data = 8'h00;
    logic         send_req = 1'b0;
    logic         write_done = 1'b0;
    logic [127:0] message_out;
    logic         data_ready;
    logic [4:0]   char_count;
    logic         busy;
    logic         dropped;
    logic         timeout;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    msg_tx_controller #(
        .MSG_BYTES      (NB),
        .AUTO_SEND      (1'b1),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .send_req    (send_req),
        .write_done  (write_done),
        .message_out (message_out),
        .data_ready  (data_ready),
        .char_count  (char_count),
        .busy        (busy),
        .dropped     (dropped),
        .timeout     (timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_buf[$];     // bytes in the message, oldest first
    int         m_phase = P_COLLECT;
    int         m_wait  = 0;  // SEND cycles elapsed without done
    bit         m_drop  = 1'b0;
    bit         m_tmo   = 1'b0;
    bit         wd_q[$];      // write_done as sampled at past edges, newest last

    function automatic logic [127:0] m_msg();
        logic [127:0] m = '0;
        for (int i = 0; i < m_buf.size(); i++) m[127-8*i -: 8] = m_buf[i];
        return m;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_buf.delete();
            wd_q.delete();
            m_phase = P_COLLECT;
            m_wait  = 0;
            m_drop  = 1'b0;
            m_tmo   = 1'b0;
        end else begin
            bit wd_s;
            bit full_hit;
            wd_s     = (wd_q.size() >= SYNC) ? wd_q[wd_q.size()-SYNC] : 1'b0;
            full_hit = 1'b0;
            m_drop   = 1'b0;
            m_tmo    = 1'b0;
            if (m_phase == P_COLLECT) begin
                if (char_valid) begin
                    if (char_data == 8'd127) begin
                        if (m_buf.size() > 0) void'(m_buf.pop_back());
                    end else if (m_buf.size() < NB) begin
                        m_buf.push_back(char_data);
                        full_hit = (m_buf.size() == NB);
                    end else begin
                        m_drop = 1'b1;
                    end
                end
                if ((send_req && m_buf.size() > 0) || full_hit) begin
                    m_phase = P_SEND;
                    m_wait  = 0;
                end
            end else if (m_phase == P_SEND) begin
                m_drop = char_valid;
                if (wd_s) m_phase = P_REL;
                else if (m_wait == TMO - 1) begin
                    m_tmo   = 1'b1;
                    m_phase = P_COLLECT;
                end else m_wait++;
            end else begin
                m_drop = char_valid;
                if (!wd_s) begin
                    m_buf.delete();
                    m_phase = P_COLLECT;
                end
            end
            wd_q.push_back(write_done);
            if (wd_q.size() > 8) void'(wd_q.pop_front());
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (chk_en && !reset) begin
            check("message_out", message_out, m_msg());
            check("char_count",  128'(char_count), 128'(m_buf.size()));
            check("data_ready",  data_ready, m_phase == P_SEND);
            check("busy",        busy, m_phase != P_COLLECT);
            check("dropped",     dropped, m_drop);
            check("timeout",     timeout, m_tmo);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit cv, input logic [7:0] cd, input bit sr);
        char_valid = cv;
        char_data  = cd;
        send_req   = sr;
        @(negedge clock);
        char_valid = 1'b0;
        send_req   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic handshake_clear();
        write_done = 1'b1;
        idle(4);
        write_done = 1'b0;
        idle(4);
    endtask

    initial begin
        logic [127:0] all_a;
        all_a = {16{8'h61}};

        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_data_ready", data_ready, 1'b0);
        check("rst_count",      char_count, 5'd0);
        check("rst_message",    message_out, 128'h0);
        check("rst_busy",       busy, 1'b0);
        check("rst_pulses",     {dropped, timeout}, 2'b00);
        reset  = 1'b0;
        chk_en = 1'b1;

        // "hi" then send, full handshake
        step(1'b1, 8'h68, 1'b0);
        step(1'b1, 8'h69, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("hi_data_ready", data_ready, 1'b1);
        check("hi_bytes",      message_out[127:112], 16'h6869);
        check("hi_rest",       message_out[111:0], 112'h0);
        write_done = 1'b1;
        idle(2);
        check("hi_dr_held", data_ready, 1'b1);
        idle(1);
        check("hi_dr_drop", data_ready, 1'b0);
        check("hi_release_busy", busy, 1'b1);
        write_done = 1'b0;
        idle(3);
        check("hi_cleared_count", char_count, 5'd0);
        check("hi_cleared_msg",   message_out, 128'h0);
        check("hi_idle_busy",     busy, 1'b0);

        // auto send on full buffer, drop during SEND, timeout, drop at full
        for (int i = 0; i < NB; i++) step(1'b1, 8'h61, 1'b0);
        check("auto_dr",    data_ready, 1'b1);
        check("auto_count", char_count, 5'd16);
        step(1'b1, 8'h62, 1'b0);
        check("auto_dropped", dropped, 1'b1);
        check("auto_frozen",  message_out, all_a);
        idle(7);
        check("auto_timeout", timeout, 1'b1);
        check("auto_tmo_dr",  data_ready, 1'b0);
        check("auto_kept",    char_count, 5'd16);
        step(1'b1, 8'h63, 1'b0);
        check("full_dropped", dropped, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        handshake_clear();
        check("auto_cleared", char_count, 5'd0);

        // deletes down to and past empty
        step(1'b1, 8'h61, 1'b0);
        step(1'b1, 8'h62, 1'b0);
        check("del_count2", char_count, 5'd2);
        step(1'b1, 8'd127, 1'b0);
        check("del_count1", char_count, 5'd1);
        step(1'b1, 8'd127, 1'b0);
        check("del_count0", char_count, 5'd0);
        step(1'b1, 8'd127, 1'b0);
        check("del_empty",    char_count, 5'd0);
        check("del_no_drop",  dropped, 1'b0);
        check("del_msg_zero", message_out, 128'h0);
        step(1'b0, 8'h00, 1'b1);
        check("del_no_send", data_ready, 1'b0);

        // timeout on a one-byte message
        step(1'b1, 8'h78, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        idle(7);
        check("tmo_not_yet", timeout, 1'b0);
        check("tmo_dr_held", data_ready, 1'b1);
        idle(1);
        check("tmo_pulse", timeout, 1'b1);
        check("tmo_dr",    data_ready, 1'b0);
        check("tmo_count", char_count, 5'd1);
        check("tmo_byte0", message_out[127:120], 8'h78);
        step(1'b0, 8'h00, 1'b1);
        handshake_clear();

        // simultaneous character and send on an empty buffer
        step(1'b1, 8'h7A, 1'b1);
        check("same_busy",  busy, 1'b1);
        check("same_dr",    data_ready, 1'b1);
        check("same_byte0", message_out[127:120], 8'h7A);

        // asynchronous reset in SEND, checked before the next clock edge
        #2 reset = 1'b1;
        #1;
        check("arst_dr",    data_ready, 1'b0);
        check("arst_count", char_count, 5'd0);
        check("arst_msg",   message_out, 128'h0);
        check("arst_busy",  busy, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // randomized traffic
        for (int ph = 0; ph < 2; ph++) begin
            repeat (1500) begin
                bit         cv;
                bit         sr;
                logic [7:0] cd;
                cv = (ph == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 0);
                cd = ($urandom_range(0, 5) == 0) ? 8'd127 : 8'($urandom_range(32, 126));
                sr = (ph == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 5) == 0) write_done = ~write_done;
                step(cv, cd, sr);
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
